// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_pkg
// Brief    : Shared types and defaults for the multiplier-sharing arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_TIMEOUT = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin pick, searching from ptr+1 upward with wrap.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        // i = NREQ lands back on ptr itself, so it has lowest priority
        for (int i = 1; i <= NREQ; i++) begin
            if (!any_o && req_i[(int'(ptr_i) + i) % NREQ]) begin
                any_o                               = 1'b1;
                grant_o[(int'(ptr_i) + i) % NREQ]   = 1'b1;
                idx_o                               = IDW'((int'(ptr_i) + i) % NREQ);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Brief    : Round-robin sharing of one sequential multiplier with watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*WIDTH-1:0]   req_a_i,
    input  logic [NREQ*WIDTH-1:0]   req_b_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic                    mul_enable_o,
    output logic [WIDTH-1:0]        mul_a_o,
    output logic [WIDTH-1:0]        mul_b_o,
    input  logic                    mul_done_i,
    input  logic [2*WIDTH-1:0]      mul_product_i,
    output logic                    rsp_valid_o,
    output logic [$clog2(NREQ)-1:0] rsp_id_o,
    output logic [2*WIDTH-1:0]      rsp_product_o,
    output logic                    rsp_error_o,
    input  logic                    rsp_ready_i
);

    localparam int             IDW       = $clog2(NREQ);
    localparam int             TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  c_TIMEOUT = TW'(TIMEOUT);

    state_t               r_state;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_id;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_mul_enable;
    logic [TW-1:0]        r_timer;
    logic                 r_rsp_valid;
    logic [2*WIDTH-1:0]   r_rsp_product;
    logic                 r_rsp_error;

    logic [NREQ-1:0]      w_grant;
    logic [IDW-1:0]       w_idx;
    logic                 w_any;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_i   (req_valid_i),
        .ptr_i   (r_ptr),
        .grant_o (w_grant),
        .idx_o   (w_idx),
        .any_o   (w_any)
    );

    assign w_a = req_a_i[int'(w_idx)*WIDTH +: WIDTH];
    assign w_b = req_b_i[int'(w_idx)*WIDTH +: WIDTH];

    // Gated by reset_ni so every output reads 0 while reset is held
    assign req_ready_o   = (r_state == IDLE && reset_ni) ? w_grant : '0;
    assign mul_enable_o  = r_mul_enable;
    assign mul_a_o       = r_a;
    assign mul_b_o       = r_b;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_id_o      = r_id;
    assign rsp_product_o = r_rsp_product;
    assign rsp_error_o   = r_rsp_error;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= IDLE;
            r_ptr         <= IDW'(NREQ - 1);
            r_id          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_mul_enable  <= 1'b0;
            r_timer       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_product <= '0;
            r_rsp_error   <= 1'b0;
        end else begin
            r_mul_enable <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a          <= w_a;
                        r_b          <= w_b;
                        r_id         <= w_idx;
                        r_mul_enable <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_timer <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_timer != c_TIMEOUT) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    // Completion takes precedence over a coincident expiry
                    if (mul_done_i) begin
                        r_rsp_product <= mul_product_i;
                        r_rsp_error   <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else if (r_timer == c_TIMEOUT) begin
                        r_rsp_product <= '0;
                        r_rsp_error   <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= r_id;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
